// File: rtl/id_ex_stage.sv
// id_ex_stage: decode, bypass, load-use stall detection and the ID/EX pipeline register
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc4,
    input  logic        id_valid,
    input  logic        flush,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    output logic        stall,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        ex_alusrc,
    output logic        ex_illegal,
    output logic [1:0]  ex_aluop,
    output logic [31:0] ex_opa,
    output logic [31:0] ex_opb,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dest,
    output logic [31:0] ex_pc4
);
    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        alusrc;
        logic        illegal;
        logic [1:0]  aluop;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] pc4;
    } ex_t;
    ex_t ex_d, ex_q;
    logic [5:0] op;
    logic is_r, is_lw, is_sw, is_beq, is_addi, legal, uses_rt, load;
    assign op        = id_instr[31:26];
    assign rf_raddr1 = id_instr[25:21];
    assign rf_raddr2 = id_instr[20:16];
    assign is_r      = op == 6'b000000;
    assign is_lw     = op == 6'b100011;
    assign is_sw     = op == 6'b101011;
    assign is_beq    = op == 6'b000100;
    assign is_addi   = op == 6'b001000;
    assign legal     = is_r | is_lw | is_sw | is_beq | is_addi;
    assign uses_rt   = is_r | is_sw | is_beq;
    assign stall     = id_valid & ~flush & ex_q.valid & ex_q.memread &
                       ((ex_q.dest == rf_raddr1) | (uses_rt & (ex_q.dest == rf_raddr2)));
    assign load      = id_valid & ~flush & ~stall;
    always_comb begin
        ex_d          = '0;
        ex_d.valid    = load;
        ex_d.regwrite = load & (is_r | is_lw | is_addi);
        ex_d.memread  = load & is_lw;
        ex_d.memwrite = load & is_sw;
        ex_d.memtoreg = load & is_lw;
        ex_d.alusrc   = load & (is_lw | is_sw | is_addi);
        ex_d.illegal  = load & ~legal;
        ex_d.aluop    = is_r ? 2'b10 : is_beq ? 2'b01 : 2'b00;
        ex_d.opa      = (wb_regwrite && wb_waddr == rf_raddr1) ? wb_wdata : rf_rdata1;
        ex_d.opb      = (wb_regwrite && wb_waddr == rf_raddr2) ? wb_wdata : rf_rdata2;
        ex_d.imm      = {{16{id_instr[15]}}, id_instr[15:0]};
        ex_d.rs       = rf_raddr1;
        ex_d.rt       = rf_raddr2;
        ex_d.dest     = is_r ? id_instr[15:11] : id_instr[20:16];
        ex_d.pc4      = id_pc4;
    end
    always_ff @(posedge clk) begin
        if (reset) ex_q <= '0;
        else ex_q <= ex_d;
    end
    assign ex_valid    = ex_q.valid;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_memtoreg = ex_q.memtoreg;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_illegal  = ex_q.illegal;
    assign ex_aluop    = ex_q.aluop;
    assign ex_opa      = ex_q.opa;
    assign ex_opb      = ex_q.opb;
    assign ex_imm      = ex_q.imm;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_dest     = ex_q.dest;
    assign ex_pc4      = ex_q.pc4;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against an instruction-level model
module tb_id_ex_stage;
    logic        clk = 0, reset = 1;
    logic [31:0] id_instr = 0, id_pc4 = 0, rf_rdata1 = 0, rf_rdata2 = 0, wb_wdata = 0;
    logic        id_valid = 0, flush = 0, wb_regwrite = 0;
    logic [4:0]  wb_waddr = 0, rf_raddr1, rf_raddr2, ex_rs, ex_rt, ex_dest;
    logic        stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_illegal;
    logic [1:0]  ex_aluop;
    logic [31:0] ex_opa, ex_opb, ex_imm, ex_pc4;
    int checks = 0, errors = 0;

    // expected contents of the EX stage, one entry per decoded instruction
    typedef struct {
        bit valid, rw, mr, mw, mtr, as, ill;
        int aluop;
        bit [31:0] opa, opb, imm, pc4;
        int rs, rt, dest;
    } exp_t;
    exp_t m, nx;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid),
        .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .wb_regwrite(wb_regwrite), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .stall(stall), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc),
        .ex_illegal(ex_illegal), .ex_aluop(ex_aluop), .ex_opa(ex_opa), .ex_opb(ex_opb),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_pc4(ex_pc4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit v, input bit fl, input bit [31:0] ins,
                         input bit [31:0] r1, input bit [31:0] r2,
                         input bit wr, input bit [4:0] wa, input bit [31:0] wd);
        reset = rst; id_valid = v; flush = fl; id_instr = ins; id_pc4 = $urandom;
        rf_rdata1 = r1; rf_rdata2 = r2; wb_regwrite = wr; wb_waddr = wa; wb_wdata = wd;
        #1;
    endtask

    // checks combinational outputs, clocks once, then checks the registered outputs
    task automatic step();
        int op, rs, rt, rd;
        bit haz, take, rtype, lw, sw, beq, addi;
        op = int'(id_instr[31:26]); rs = int'(id_instr[25:21]);
        rt = int'(id_instr[20:16]); rd = int'(id_instr[15:11]);
        rtype = op == 0; lw = op == 35; sw = op == 43; beq = op == 4; addi = op == 8;
        haz = id_valid && !flush && m.valid && m.mr && (m.dest == rs || ((rtype || sw || beq) && m.dest == rt));
        take = id_valid && !flush && !haz;
        chk("stall", 32'(stall), 32'(haz));
        chk("raddr1", 32'(rf_raddr1), rs);
        chk("raddr2", 32'(rf_raddr2), rt);
        nx = '{default: 0};
        if (!reset) begin
            nx.opa = (wb_regwrite && wb_waddr == rs) ? wb_wdata : rf_rdata1;
            nx.opb = (wb_regwrite && wb_waddr == rt) ? wb_wdata : rf_rdata2;
            nx.imm = 32'($signed(id_instr[15:0]));
            nx.pc4 = id_pc4; nx.rs = rs; nx.rt = rt; nx.dest = rtype ? rd : rt;
            nx.aluop = rtype ? 2 : beq ? 1 : 0;
            if (take) begin
                nx.valid = 1;
                nx.ill = !(rtype || lw || sw || beq || addi);
                nx.rw = rtype || lw || addi;
                nx.mr = lw; nx.mtr = lw; nx.mw = sw; nx.as = lw || sw || addi;
            end
        end
        @(posedge clk); #1;
        m = nx;
        chk("ex_valid", 32'(ex_valid), 32'(m.valid));
        chk("ex_regwrite", 32'(ex_regwrite), 32'(m.rw));
        chk("ex_memread", 32'(ex_memread), 32'(m.mr));
        chk("ex_memwrite", 32'(ex_memwrite), 32'(m.mw));
        chk("ex_memtoreg", 32'(ex_memtoreg), 32'(m.mtr));
        chk("ex_alusrc", 32'(ex_alusrc), 32'(m.as));
        chk("ex_illegal", 32'(ex_illegal), 32'(m.ill));
        chk("ex_opa", ex_opa, m.opa);
        chk("ex_opb", ex_opb, m.opb);
        chk("ex_imm", ex_imm, m.imm);
        chk("ex_rs", 32'(ex_rs), m.rs);
        chk("ex_rt", 32'(ex_rt), m.rt);
        chk("ex_pc4", ex_pc4, m.pc4);
        if (m.valid && !m.ill) chk("ex_aluop", 32'(ex_aluop), m.aluop);
        if (m.rw || m.mr) chk("ex_dest", 32'(ex_dest), m.dest);
    endtask

    localparam bit [31:0] LW2 = 32'h8C02_0000, ADD = 32'h0022_1820, ILL = 32'hFC00_0000;

    initial begin
        m = '{default: 0};
        drive(1, 1, 0, LW2, 7, 9, 0, 0, 0); step();
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_memread", 32'(ex_memread), 0);
        chk("rst_opa", ex_opa, 0);
        chk("rst_stall", 32'(stall), 0);
        drive(0, 1, 0, ADD, 4, 6, 0, 0, 0); step();
        chk("add_opa", ex_opa, 4);
        chk("add_opb", ex_opb, 6);
        chk("add_dest", 32'(ex_dest), 3);
        chk("add_regwrite", 32'(ex_regwrite), 1);
        chk("add_aluop", 32'(ex_aluop), 2);
        drive(0, 1, 0, ADD, 4, 6, 1, 2, 32'h55); step();
        chk("byp_opb", ex_opb, 32'h55);
        drive(0, 1, 0, ADD, 4, 6, 0, 2, 32'h55); step();
        chk("nobyp_opb", ex_opb, 6);
        drive(0, 1, 0, LW2, 0, 0, 0, 0, 0); step();
        drive(0, 1, 0, ADD, 4, 6, 0, 0, 0);
        chk("lu_stall", 32'(stall), 1);
        step();
        chk("lu_bubble", 32'(ex_valid), 0);
        chk("lu_stall_clear", 32'(stall), 0);
        step();
        chk("lu_add_valid", 32'(ex_valid), 1);
        chk("lu_add_dest", 32'(ex_dest), 3);
        drive(0, 1, 0, LW2, 0, 0, 0, 0, 0); step();
        drive(0, 1, 1, ADD, 4, 6, 0, 0, 0);
        chk("fl_stall", 32'(stall), 0);
        step();
        chk("fl_valid", 32'(ex_valid), 0);
        drive(0, 1, 0, ILL, 1, 2, 0, 0, 0); step();
        chk("ill_valid", 32'(ex_valid), 1);
        chk("ill_illegal", 32'(ex_illegal), 1);
        chk("ill_regwrite", 32'(ex_regwrite), 0);
        chk("ill_memwrite", 32'(ex_memwrite), 0);
        for (int i = 0; i < 3000; i++) begin
            bit [5:0] op;
            bit [31:0] ins;
            case ($urandom_range(0, 6))
                0: op = 6'h00;
                1, 2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                5: op = 6'h08;
                default: op = 6'($urandom);
            endcase
            ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 11'($urandom)};
            drive($urandom_range(0, 99) < 3, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, ins,
                  $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
